// File: rtl/mem_access_unit.sv
// Load/store unit between execute and writeback: one outstanding data-memory
// access with alignment check, ack timeout, store lane packing and load extension.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  instr_id,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_we,
    output logic        misaligned,
    output logic        bus_err
);

    localparam logic [5:0] INSTR_LB  = 6'h10;
    localparam logic [5:0] INSTR_LH  = 6'h11;
    localparam logic [5:0] INSTR_LW  = 6'h12;
    localparam logic [5:0] INSTR_LBU = 6'h13;
    localparam logic [5:0] INSTR_LHU = 6'h14;
    localparam logic [5:0] INSTR_SB  = 6'h18;
    localparam logic [5:0] INSTR_SH  = 6'h19;
    localparam logic [5:0] INSTR_SW  = 6'h1A;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RESP
    } state_t;

    function automatic logic is_load(input logic [5:0] id);
        return (id == INSTR_LB) || (id == INSTR_LH) || (id == INSTR_LW) ||
               (id == INSTR_LBU) || (id == INSTR_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] id);
        return (id == INSTR_SB) || (id == INSTR_SH) || (id == INSTR_SW);
    endfunction

    function automatic logic is_misaligned(input logic [5:0] id, input logic [1:0] lo);
        logic half;
        logic word;
        half = (id == INSTR_LH) || (id == INSTR_LHU) || (id == INSTR_SH);
        word = (id == INSTR_LW) || (id == INSTR_SW);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

    function automatic logic [31:0] load_ext(input logic [5:0] id, input logic [1:0] lane,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (id)
            INSTR_LB:  return {{24{b[7]}}, b};
            INSTR_LBU: return {24'h0, b};
            INSTR_LH:  return {{16{h[15]}}, h};
            INSTR_LHU: return {16'h0, h};
            default:   return d;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  instr_q, instr_d;
    logic [1:0]  lane_q, lane_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_we_q, out_we_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        lane_d      = lane_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_we_d    = 1'b0;
        mis_d       = 1'b0;
        berr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d  = instr_id;
                    lane_d   = alu_result[1:0];
                    out_rd_d = rd_addr;
                    if (!is_load(instr_id) && !is_store(instr_id)) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_data_d  = alu_result;
                        out_we_d    = (rd_addr != 5'd0);
                    end else if (is_misaligned(instr_id, alu_result[1:0])) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        mis_d       = 1'b1;
                    end else begin
                        state_d = WAIT_ACK;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = is_store(instr_id);
                        addr_d  = {alu_result[31:2], 2'b00};
                        case (instr_id)
                            INSTR_SB: begin
                                wdata_d = {4{store_data[7:0]}};
                                wstrb_d = 4'b0001 << alu_result[1:0];
                            end
                            INSTR_SH: begin
                                wdata_d = {2{store_data[15:0]}};
                                wstrb_d = alu_result[1] ? 4'b1100 : 4'b0011;
                            end
                            INSTR_SW: begin
                                wdata_d = store_data;
                                wstrb_d = 4'b1111;
                            end
                            default: begin
                                wdata_d = '0;
                                wstrb_d = '0;
                            end
                        endcase
                    end
                end
            end
            WAIT_ACK: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (dmem_ack || (cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    out_valid_d = 1'b1;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = '0;
                    wdata_d     = '0;
                    wstrb_d     = '0;
                    if (!dmem_ack) begin
                        berr_d = 1'b1;
                    end else if (is_load(instr_q)) begin
                        out_data_d = load_ext(instr_q, lane_q, dmem_rdata);
                        out_we_d   = (out_rd_q != 5'd0);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            instr_q     <= '0;
            lane_q      <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            lane_q      <= lane_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_we_q    <= out_we_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign out_valid  = out_valid_q;
    assign out_rd     = out_rd_q;
    assign out_data   = out_data_q;
    assign out_we     = out_we_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU passthrough, loads, stores,
// misalignment, ack timeout and reset abort.
module tb_mem_access_unit;

    localparam logic [5:0] INSTR_ADD = 6'h01;
    localparam logic [5:0] INSTR_LB  = 6'h10;
    localparam logic [5:0] INSTR_LW  = 6'h12;
    localparam logic [5:0] INSTR_LHU = 6'h14;
    localparam logic [5:0] INSTR_SB  = 6'h18;
    localparam logic [5:0] INSTR_SH  = 6'h19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  instr_id;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_we;
    logic        misaligned;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_id(instr_id), .alu_result(alu_result), .store_data(store_data),
        .rd_addr(rd_addr), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
        .out_rd(out_rd), .out_data(out_data), .out_we(out_we),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one op at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [5:0] id, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        @(negedge clk);
        in_valid   = 1'b1;
        instr_id   = id;
        alu_result = a;
        store_data = sd;
        rd_addr    = rd;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'h0, dmem_req},   32'h0);
        check({tag, "_we"},    {31'h0, dmem_we},    32'h0);
        check({tag, "_addr"},  dmem_addr,           32'h0);
        check({tag, "_wdata"}, dmem_wdata,          32'h0);
        check({tag, "_wstrb"}, {28'h0, dmem_wstrb}, 32'h0);
        check({tag, "_ov"},    {31'h0, out_valid},  32'h0);
        check({tag, "_owe"},   {31'h0, out_we},     32'h0);
        check({tag, "_odata"}, out_data,            32'h0);
        check({tag, "_ord"},   {27'h0, out_rd},     32'h0);
        check({tag, "_mis"},   {31'h0, misaligned}, 32'h0);
        check({tag, "_berr"},  {31'h0, bus_err},    32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr_id   = '0;
        alu_result = '0;
        store_data = '0;
        rd_addr    = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'h0, in_ready}, 32'h1);

        // ADD: result next cycle, no memory request
        issue(INSTR_ADD, 32'h0000_1234, 32'h0, 5'd5);
        check("add_ov",    {31'h0, out_valid}, 32'h1);
        check("add_data",  out_data,           32'h0000_1234);
        check("add_we",    {31'h0, out_we},    32'h1);
        check("add_rd",    {27'h0, out_rd},    32'd5);
        check("add_req",   {31'h0, dmem_req},  32'h0);
        check("add_busy",  {31'h0, in_ready},  32'h0);
        @(negedge clk);
        check("add_ov_off", {31'h0, out_valid}, 32'h0);
        check("add_rdy",    {31'h0, in_ready},  32'h1);

        // Stray ack while idle has no effect
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("stray_ov",  {31'h0, out_valid}, 32'h0);
        check("stray_rdy", {31'h0, in_ready},  32'h1);

        // LB 0x103, ack after 3 cycles of request
        issue(INSTR_LB, 32'h0000_0103, 32'h0, 5'd7);
        check("lb_req",   {31'h0, dmem_req},   32'h1);
        check("lb_addr",  dmem_addr,           32'h0000_0100);
        check("lb_wstrb", {28'h0, dmem_wstrb}, 32'h0);
        check("lb_we",    {31'h0, dmem_we},    32'h0);
        @(negedge clk);
        check("lb_hold",  {31'h0, dmem_req},   32'h1);
        @(negedge clk);
        check("lb_hold2", dmem_addr,           32'h0000_0100);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80AB_CDEF;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("lb_ov",    {31'h0, out_valid}, 32'h1);
        check("lb_data",  out_data,           32'hFFFF_FF80);
        check("lb_owe",   {31'h0, out_we},    32'h1);
        check("lb_rd",    {27'h0, out_rd},    32'd7);
        check("lb_reqoff",{31'h0, dmem_req},  32'h0);
        @(negedge clk);
        check("lb_ov_off",{31'h0, out_valid}, 32'h0);

        // SH 0x202, ack on first request cycle
        issue(INSTR_SH, 32'h0000_0202, 32'h1234_BEEF, 5'd9);
        check("sh_req",   {31'h0, dmem_req},   32'h1);
        check("sh_we",    {31'h0, dmem_we},    32'h1);
        check("sh_addr",  dmem_addr,           32'h0000_0200);
        check("sh_wdata", dmem_wdata,          32'hBEEF_BEEF);
        check("sh_wstrb", {28'h0, dmem_wstrb}, 32'hC);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("sh_ov",    {31'h0, out_valid}, 32'h1);
        check("sh_owe",   {31'h0, out_we},    32'h0);
        check("sh_req_off",{31'h0, dmem_req}, 32'h0);

        // SB 0x301: byte replicated, strobe shifted to lane 1
        issue(INSTR_SB, 32'h0000_0301, 32'h7777_66A5, 5'd0);
        check("sb_wdata", dmem_wdata,          32'hA5A5_A5A5);
        check("sb_wstrb", {28'h0, dmem_wstrb}, 32'h2);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("sb_ov",    {31'h0, out_valid}, 32'h1);

        // LHU 0x402: upper half zero-extended
        issue(INSTR_LHU, 32'h0000_0402, 32'h0, 5'd4);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80AB_1234;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("lhu_data", out_data,        32'h0000_80AB);
        check("lhu_owe",  {31'h0, out_we}, 32'h1);

        // LW misaligned
        issue(INSTR_LW, 32'h0000_0101, 32'h0, 5'd6);
        check("mis_req", {31'h0, dmem_req},   32'h0);
        check("mis_ov",  {31'h0, out_valid},  32'h1);
        check("mis_flag",{31'h0, misaligned}, 32'h1);
        check("mis_owe", {31'h0, out_we},     32'h0);
        @(negedge clk);
        check("mis_off", {31'h0, misaligned}, 32'h0);

        // LW with ack withheld: request lasts exactly 16 cycles
        issue(INSTR_LW, 32'h0000_0500, 32'h0, 5'd3);
        cyc = 0;
        for (int i = 0; i < 100 && dmem_req; i++) begin
            cyc++;
            @(negedge clk);
        end
        check("to_cycles", cyc,                 32'd16);
        check("to_ov",     {31'h0, out_valid},  32'h1);
        check("to_berr",   {31'h0, bus_err},    32'h1);
        check("to_owe",    {31'h0, out_we},     32'h0);
        issue(INSTR_ADD, 32'h0000_00AA, 32'h0, 5'd2);
        check("b2b_ov",    {31'h0, out_valid},  32'h1);
        check("b2b_data",  out_data,            32'h0000_00AA);
        check("b2b_berr",  {31'h0, bus_err},    32'h0);

        // Reset in the middle of WAIT_ACK, ack after release
        issue(INSTR_LW, 32'h0000_0600, 32'h0, 5'd8);
        check("ra_req", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("ra");
        @(negedge clk);
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("ra_ov",  {31'h0, out_valid}, 32'h0);
        check("ra_rdy", {31'h0, in_ready},  32'h1);
        check("ra_req2",{31'h0, dmem_req},  32'h0);
        @(negedge clk);
        check("ra_ov2", {31'h0, out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
